// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - NCH-input valid/ready stream mux with fixed-select and round-robin modes
// Registered output stage; out_ch tags each word with the channel it came from.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCH = 2,
  localparam int CW = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [CW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             can_load;
  logic [NCH-1:0]   grant;
  logic [CW-1:0]    grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic [CW-1:0]    rr_ptr;

  assign can_load = !out_valid || out_ready;

  // Round-robin scans offsets from farthest to nearest so the nearest
  // requester after rr_ptr is the last (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (can_load) begin
      if (!mode) begin
        for (int i = 0; i < NCH; i++) begin
          if (sel == CW'(i) && in_valid[i]) begin
            grant[i]  = 1'b1;
            grant_idx = CW'(i);
          end
        end
      end else begin
        for (int k = NCH; k >= 1; k--) begin
          for (int i = 0; i < NCH; i++) begin
            if (i == (int'(rr_ptr) + k) % NCH && in_valid[i]) begin
              grant     = '0;
              grant[i]  = 1'b1;
              grant_idx = CW'(i);
            end
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign xfer     = |grant;
  assign in_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= CW'(NCH - 1);
    end else begin
      if (xfer) begin
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        out_valid <= 1'b1;
        if (mode) rr_ptr <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard bench for stream_mux_rr (NCH=3, WIDTH=4)
module tb_stream_mux_rr;

  localparam int WIDTH = 4;
  localparam int NCH = 3;
  localparam int CW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mode;
  logic [CW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]     in_valid;
  logic [NCH-1:0]     in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_ch;
  logic               out_valid;
  logic               out_ready;

  int total = 0;
  int bad = 0;
  logic [CW+WIDTH-1:0] exp_q[$];

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [CW-1:0] ch, input logic [WIDTH-1:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each word seen with out_valid && out_ready at the falling edge is consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got ch=%0d data=%0h expected none", out_ch, out_data);
      end else begin
        logic [CW+WIDTH-1:0] e;
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          bad++;
          $display("FAIL sb_word: got ch=%0d data=%0h expected ch=%0d data=%0h",
                   out_ch, out_data, e[CW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_out_ch", 32'(out_ch), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // fixed select, ch1 chosen while ch0 also requests
    mode = 1'b0; sel = 2'd1; in_valid = 3'b011; in_data = {4'h0, 4'hB, 4'h6}; out_ready = 1'b1;
    #1 chk("fixed_in_ready0", 32'(in_ready), 32'b010);
    push(2'd1, 4'hB); push(2'd1, 4'hB);
    step();
    chk("fixed_in_ready1", 32'(in_ready), 32'b010);
    chk("fixed_out_valid", 32'(out_valid), 32'h1);
    step();
    in_valid = '0;
    step(); step();

    // round-robin, all requesting: 0,1,2,0,1,2 back to back
    mode = 1'b1; in_valid = 3'b111; in_data = {4'h3, 4'h2, 4'h1};
    #1 chk("rr_first_ready", 32'(in_ready), 32'b001);
    for (int i = 0; i < 6; i++) begin
      push(CW'(i % 3), WIDTH'(i % 3 + 1));
      step();
      chk("rr_no_bubble", 32'(out_valid), 32'h1);
    end
    in_valid = '0;
    step(); step();

    // wrap-around after a ch2 grant with ch1 idle
    in_valid = 3'b101;
    #1 chk("rr_wrap_ready", 32'(in_ready), 32'b001);
    push(2'd0, 4'h1); push(2'd2, 4'h3); push(2'd0, 4'h1);
    step();
    chk("rr_skip_ready", 32'(in_ready), 32'b100);
    step(); step();
    in_valid = '0;
    step(); step();

    // backpressure holding 4'h9
    mode = 1'b0; sel = 2'd1; in_valid = 3'b010; in_data = {4'h3, 4'h9, 4'h1};
    push(2'd1, 4'h9);
    step();
    mode = 1'b1; in_valid = 3'b111; in_data = {4'h3, 4'h2, 4'h1}; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_data", 32'(out_data), 32'h9);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'b010);
    push(2'd1, 4'h2);
    step();
    in_valid = '0;
    step(); step();

    // sel out of range drains and stalls
    mode = 1'b0; sel = 2'd2; in_valid = 3'b111;
    push(2'd2, 4'h3);
    step();
    sel = 2'd3;
    #1 chk("sel_oor_ready", 32'(in_ready), 32'h0);
    step();
    chk("sel_oor_drained", 32'(out_valid), 32'h0);
    chk("sel_oor_data_hold", 32'(out_data), 32'h3);
    in_valid = '0;
    step();

    // async reset with a word held; rr_ptr is 1 here, so ch0 wins and ptr becomes 0
    mode = 1'b1; in_valid = 3'b011;
    step();
    in_valid = '0; out_ready = 1'b0;
    #1 chk("pre_reset_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1 chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_out_data", 32'(out_data), 32'h0);
    step();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 3'b111;
    #1 chk("post_reset_ready", 32'(in_ready), 32'b001);
    push(2'd0, 4'h1);
    step();
    in_valid = '0;
    step(); step(); step();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
